// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: major opcodes, ALU function codes and the
// decoded-control bundle passed from the decoder into the ID/EX register.
package rv32i_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // ALU function codes share the funct3 encoding of OP/OP-IMM
   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SLL  = 3'd1;
   localparam logic [2:0] ALU_SLT  = 3'd2;
   localparam logic [2:0] ALU_SLTU = 3'd3;
   localparam logic [2:0] ALU_XOR  = 3'd4;
   localparam logic [2:0] ALU_SR   = 3'd5;
   localparam logic [2:0] ALU_OR   = 3'd6;
   localparam logic [2:0] ALU_AND  = 3'd7;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  sel;
      logic        ext;
      logic        we;
      logic        is_branch;
      logic        illegal;
   } decode_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Sign-extended I/S immediates and the upper-20 U immediate of an RV32I word.
// Only bits [31:7] carry immediate fields, so the opcode is not brought in.
module rv32i_imm_gen
   import rv32i_pkg::*;
(
   input  logic [31:7] instr,
   output logic [31:0] imm_i,
   output logic [31:0] imm_s,
   output logic [31:0] imm_u
);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_u = {instr[31:12], 12'b0};

endmodule

// File: rtl/rv32i_id_ex_stage.sv
// RV32I decode/issue stage feeding the ALU through a single-entry ID/EX register.
// Optional writeback bypass on the operand reads: define RV32I_IDEX_WB_BYPASS_EN.
module rv32i_id_ex_stage
   import rv32i_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [31:0]     in_pc,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
`ifdef RV32I_IDEX_WB_BYPASS_EN
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
`endif
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [2:0]      alu_sel,
   output logic            alu_ext,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_we,
   output logic            ex_is_branch,
   output logic [2:0]      ex_funct3,
   output logic [31:0]     ex_pc,
   output logic            ex_illegal
);

   logic [31:0]     imm_i;
   logic [31:0]     imm_s;
   logic [31:0]     imm_u;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic [2:0]      funct3;
   logic [4:0]      rd;
   logic            accept;
   decode_t         dec;

   assign rs1_addr = in_instr[19:15];
   assign rs2_addr = in_instr[24:20];
   assign funct3   = in_instr[14:12];
   assign rd       = in_instr[11:7];
   assign in_ready = !ex_valid || ex_ready;
   assign accept   = in_valid && in_ready && !flush;

   rv32i_imm_gen u_imm_gen (
      .instr (in_instr[31:7]),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_u (imm_u)
   );

`ifdef RV32I_IDEX_WB_BYPASS_EN
   // A writeback landing this cycle is newer than the regfile read port
   assign op1 = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) ? wb_data : rs1_data;
   assign op2 = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) ? wb_data : rs2_data;
`else
   assign op1 = rs1_data;
   assign op2 = rs2_data;
`endif

   always_comb begin
      dec     = '0;
      dec.sel = ALU_ADD;
      case (in_instr[6:0])
         OPC_OP: begin
            dec.a   = op1;
            dec.b   = op2;
            dec.sel = funct3;
            dec.ext = in_instr[30];
            dec.we  = 1'b1;
         end
         OPC_OP_IMM: begin
            dec.a   = op1;
            dec.b   = imm_i;
            dec.sel = funct3;
            dec.ext = (funct3 == ALU_SR) && in_instr[30];
            dec.we  = 1'b1;
         end
         OPC_LUI: begin
            dec.b  = imm_u;
            dec.we = 1'b1;
         end
         OPC_AUIPC: begin
            dec.a  = in_pc;
            dec.b  = imm_u;
            dec.we = 1'b1;
         end
         OPC_LOAD: begin
            dec.a  = op1;
            dec.b  = imm_i;
            dec.we = 1'b1;
         end
         OPC_STORE: begin
            dec.a = op1;
            dec.b = imm_s;
         end
         OPC_JAL, OPC_JALR: begin
            dec.a  = in_pc;
            dec.b  = 32'd4;
            dec.we = 1'b1;
         end
         OPC_BRANCH: begin
            dec.a         = op1;
            dec.b         = op2;
            dec.ext       = 1'b1;
            dec.is_branch = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   // Flush beats both accept and stall; data registers only move on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_sel      <= ALU_ADD;
         alu_ext      <= 1'b0;
         ex_rd        <= 5'd0;
         ex_reg_we    <= 1'b0;
         ex_is_branch <= 1'b0;
         ex_funct3    <= 3'd0;
         ex_pc        <= RESET_PC;
         ex_illegal   <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (accept) begin
         ex_valid     <= 1'b1;
         alu_a        <= dec.a;
         alu_b        <= dec.b;
         alu_sel      <= dec.sel;
         alu_ext      <= dec.ext;
         ex_rd        <= rd;
         ex_reg_we    <= dec.we && (rd != 5'd0);
         ex_is_branch <= dec.is_branch;
         ex_funct3    <= funct3;
         ex_pc        <= in_pc;
         ex_illegal   <= dec.illegal;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule
